// File: rtl/ysyx_24110006_pkg.sv
// Shared definitions for the load/store unit: load-type funct3 codes,
// store mask encodings and the LSU state enum.
// Imported by the LSU top and its alignment helper.
package ysyx_24110006_pkg;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/ysyx_24110006_lsu_align.sv
// Byte-lane alignment for the LSU: store shift, load extract/extend, misalign detect.
// Purely combinational, zero latency.
// No flow control; the caller decides when the outputs are sampled.
module ysyx_24110006_lsu_align
    import ysyx_24110006_pkg::*;
(
    input  logic [1:0]  acc_off_i,
    input  logic        acc_store_i,
    input  logic [3:0]  acc_mask_i,
    input  logic [2:0]  acc_read_t_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_data_o,
    output logic [3:0]  st_strb_o,
    output logic        misalign_o,
    input  logic [1:0]  ld_off_i,
    input  logic [2:0]  ld_read_t_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic       is_half;
    logic       is_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: move data and strobe onto the lanes selected by the low address bits.
    always_comb begin
        st_data_o = st_data_i << {acc_off_i, 3'b000};
        st_strb_o = acc_mask_i << acc_off_i;
    end

    // Access size comes from the mask for stores and from funct3 for loads;
    // unknown encodings fall back to word, matching how they are executed.
    always_comb begin
        is_half = 1'b0;
        is_word = 1'b0;
        if (acc_store_i) begin
            is_half = (acc_mask_i == MASK_H);
            is_word = (acc_mask_i != MASK_H) && (acc_mask_i != MASK_B);
        end else begin
            case (acc_read_t_i)
                LD_LB, LD_LBU: ;
                LD_LH, LD_LHU: is_half = 1'b1;
                default:       is_word = 1'b1;
            endcase
        end
        misalign_o = (is_half && acc_off_i[0]) || (is_word && (acc_off_i != 2'b00));
    end

    // Load side: pick the addressed byte/half, then sign- or zero-extend.
    always_comb begin
        case (ld_off_i)
            2'd0:    ld_byte = ld_rdata_i[7:0];
            2'd1:    ld_byte = ld_rdata_i[15:8];
            2'd2:    ld_byte = ld_rdata_i[23:16];
            default: ld_byte = ld_rdata_i[31:24];
        endcase
        ld_half = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        case (ld_read_t_i)
            LD_LB:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            LD_LH:   ld_data_o = {{16{ld_half[15]}}, ld_half};
            LD_LBU:  ld_data_o = {24'h0, ld_byte};
            LD_LHU:  ld_data_o = {16'h0, ld_half};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/ysyx_24110006_lsu.sv
// Load/store unit: accepts an execute-stage result, performs at most one bus access, returns write-back data.
// Latency: 1 cycle for ALU/misaligned ops, ack cycle + 1 for memory ops (minimum 2).
// Single outstanding req held until ack; no back-pressure on o_valid.
module ysyx_24110006_lsu
    import ysyx_24110006_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_result,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_mem_ren,
    input  logic              i_mem_wen,
    input  logic [3:0]        i_mem_wmask,
    input  logic [2:0]        i_mem_read_t,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [3:0]        o_mem_wstrb,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_err,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_misalign,
    output logic              o_fault,
    output logic              o_valid
);

    lsu_state_e        state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_wstrb_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              misalign_q;
    logic              fault_q;
    logic [1:0]        off_q;
    logic [2:0]        read_t_q;
    logic [DATA_W-1:0] result_q;
    logic              load_q;

    logic [DATA_W-1:0] st_data;
    logic [3:0]        st_strb;
    logic              misalign;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] wb_data_d;

    // Store side and misalign check look at the incoming request; load side
    // looks at the registered request so extraction lines up with the ack.
    ysyx_24110006_lsu_align u_align (
        .acc_off_i    (i_result[1:0]),
        .acc_store_i  (i_mem_wen),
        .acc_mask_i   (i_mem_wmask),
        .acc_read_t_i (i_mem_read_t),
        .st_data_i    (i_wdata),
        .st_data_o    (st_data),
        .st_strb_o    (st_strb),
        .misalign_o   (misalign),
        .ld_off_i     (off_q),
        .ld_read_t_i  (read_t_q),
        .ld_rdata_i   (i_mem_rdata),
        .ld_data_o    (ld_data)
    );

    // Write-back value at ack: extended load data (zero on error) or the ALU result for stores.
    always_comb begin
        wb_data_d = result_q;
        if (load_q) begin
            wb_data_d = i_mem_err ? '0 : ld_data;
        end
    end

    // Control FSM; every bus and write-back output is a register updated here.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q     <= LSU_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            wb_data_q   <= '0;
            misalign_q  <= 1'b0;
            fault_q     <= 1'b0;
            off_q       <= '0;
            read_t_q    <= '0;
            result_q    <= '0;
            load_q      <= 1'b0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (i_valid) begin
                        off_q      <= i_result[1:0];
                        read_t_q   <= i_mem_read_t;
                        result_q   <= i_result;
                        load_q     <= i_mem_ren && !i_mem_wen;
                        misalign_q <= 1'b0;
                        fault_q    <= 1'b0;
                        if (!i_mem_ren && !i_mem_wen) begin
                            wb_data_q <= i_result;
                            state_q   <= LSU_DONE;
                        end else if (misalign) begin
                            misalign_q <= 1'b1;
                            wb_data_q  <= i_mem_wen ? i_result : '0;
                            state_q    <= LSU_DONE;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= i_mem_wen;
                            mem_addr_q  <= {i_result[ADDR_W-1:2], 2'b00};
                            mem_wdata_q <= i_mem_wen ? st_data : '0;
                            mem_wstrb_q <= i_mem_wen ? st_strb : 4'b0000;
                            state_q     <= LSU_REQ;
                        end
                    end
                end
                LSU_REQ: begin
                    if (i_mem_ack) begin
                        mem_req_q <= 1'b0;
                        fault_q   <= i_mem_err;
                        wb_data_q <= wb_data_d;
                        state_q   <= LSU_DONE;
                    end
                end
                default: begin
                    state_q <= LSU_IDLE;
                end
            endcase
        end
    end

    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_wstrb = mem_wstrb_q;
    assign o_wb_data   = wb_data_q;
    assign o_misalign  = misalign_q;
    assign o_fault     = fault_q;
    assign o_valid     = (state_q == LSU_DONE);

endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
// Directed bench for the load/store unit.
// Inputs are driven and outputs sampled 1ns after each rising edge.
// Expected values are hand-computed constants.
module tb_ysyx_24110006_lsu;

    logic        i_clock = 1'b0;
    logic        i_reset_n;
    logic        i_valid;
    logic [31:0] i_result;
    logic [31:0] i_wdata;
    logic        i_mem_ren;
    logic        i_mem_wen;
    logic [3:0]  i_mem_wmask;
    logic [2:0]  i_mem_read_t;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        i_mem_err;
    logic [31:0] o_wb_data;
    logic        o_misalign;
    logic        o_fault;
    logic        o_valid;

    int checks = 0;
    int errors = 0;

    always #5 i_clock = ~i_clock;

    ysyx_24110006_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_valid      (i_valid),
        .i_result     (i_result),
        .i_wdata      (i_wdata),
        .i_mem_ren    (i_mem_ren),
        .i_mem_wen    (i_mem_wen),
        .i_mem_wmask  (i_mem_wmask),
        .i_mem_read_t (i_mem_read_t),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wstrb  (o_mem_wstrb),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_err    (i_mem_err),
        .o_wb_data    (o_wb_data),
        .o_misalign   (o_misalign),
        .o_fault      (o_fault),
        .o_valid      (o_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    // Present a one-cycle request and let the accepting edge pass.
    task automatic issue(input logic ren, input logic wen, input logic [31:0] res,
                         input logic [31:0] wd, input logic [3:0] m, input logic [2:0] rt);
        i_valid      = 1'b1;
        i_mem_ren    = ren;
        i_mem_wen    = wen;
        i_result     = res;
        i_wdata      = wd;
        i_mem_wmask  = m;
        i_mem_read_t = rt;
        step();
        i_valid   = 1'b0;
        i_mem_ren = 1'b0;
        i_mem_wen = 1'b0;
    endtask

    // Hold the request for some wait cycles, then ack for one cycle.
    task automatic ack_after(input int waits, input logic [31:0] rd, input logic err);
        for (int i = 0; i < waits; i++) begin
            step();
        end
        i_mem_ack   = 1'b1;
        i_mem_rdata = rd;
        i_mem_err   = err;
        step();
        i_mem_ack = 1'b0;
        i_mem_err = 1'b0;
    endtask

    initial begin
        i_reset_n    = 1'b0;
        i_valid      = 1'b0;
        i_result     = '0;
        i_wdata      = '0;
        i_mem_ren    = 1'b0;
        i_mem_wen    = 1'b0;
        i_mem_wmask  = '0;
        i_mem_read_t = '0;
        i_mem_ack    = 1'b0;
        i_mem_rdata  = '0;
        i_mem_err    = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_valid", {31'b0, o_valid}, 32'h0);
        chk("rst_req", {31'b0, o_mem_req}, 32'h0);
        chk("rst_we", {31'b0, o_mem_we}, 32'h0);
        chk("rst_addr", o_mem_addr, 32'h0);
        chk("rst_wdata", o_mem_wdata, 32'h0);
        chk("rst_wstrb", {28'b0, o_mem_wstrb}, 32'h0);
        chk("rst_wb", o_wb_data, 32'h0);
        chk("rst_mis", {31'b0, o_misalign}, 32'h0);
        chk("rst_fault", {31'b0, o_fault}, 32'h0);
        i_reset_n = 1'b1;
        step();

        // ALU pass-through
        issue(1'b0, 1'b0, 32'h1234_5678, 32'h0, 4'b0000, 3'b000);
        chk("alu_valid", {31'b0, o_valid}, 32'h1);
        chk("alu_req", {31'b0, o_mem_req}, 32'h0);
        chk("alu_wb", o_wb_data, 32'h1234_5678);
        step();
        chk("alu_valid_drop", {31'b0, o_valid}, 32'h0);

        // LB at 0x8000_0003, ack after 3 wait cycles
        issue(1'b1, 1'b0, 32'h8000_0003, 32'h0, 4'b0000, 3'b000);
        chk("lb_req", {31'b0, o_mem_req}, 32'h1);
        chk("lb_we", {31'b0, o_mem_we}, 32'h0);
        chk("lb_addr", o_mem_addr, 32'h8000_0000);
        chk("lb_wstrb", {28'b0, o_mem_wstrb}, 32'h0);
        step();
        step();
        chk("lb_wait_req", {31'b0, o_mem_req}, 32'h1);
        chk("lb_wait_valid", {31'b0, o_valid}, 32'h0);
        ack_after(1, 32'h80AA_BBCC, 1'b0);
        chk("lb_valid", {31'b0, o_valid}, 32'h1);
        chk("lb_req_drop", {31'b0, o_mem_req}, 32'h0);
        chk("lb_wb", o_wb_data, 32'hFFFF_FF80);
        step();

        // LBU, same access
        issue(1'b1, 1'b0, 32'h8000_0003, 32'h0, 4'b0000, 3'b100);
        ack_after(3, 32'h80AA_BBCC, 1'b0);
        chk("lbu_valid", {31'b0, o_valid}, 32'h1);
        chk("lbu_wb", o_wb_data, 32'h0000_0080);
        step();

        // LH at 0x8000_0002 picks the upper half and sign-extends
        issue(1'b1, 1'b0, 32'h8000_0002, 32'h0, 4'b0000, 3'b001);
        ack_after(0, 32'h80AA_BBCC, 1'b0);
        chk("lh_wb", o_wb_data, 32'hFFFF_80AA);
        step();

        // SH at 0x8000_0002, ack in the same cycle as the request
        issue(1'b0, 1'b1, 32'h8000_0002, 32'hDEAD_BEEF, 4'b0011, 3'b000);
        chk("sh_req", {31'b0, o_mem_req}, 32'h1);
        chk("sh_we", {31'b0, o_mem_we}, 32'h1);
        chk("sh_addr", o_mem_addr, 32'h8000_0000);
        chk("sh_wstrb", {28'b0, o_mem_wstrb}, 32'h0000_000C);
        chk("sh_wdata", o_mem_wdata, 32'hBEEF_0000);
        ack_after(0, 32'h0, 1'b0);
        chk("sh_valid", {31'b0, o_valid}, 32'h1);
        chk("sh_wb", o_wb_data, 32'h8000_0002);
        step();

        // Misaligned LW: no bus access
        issue(1'b1, 1'b0, 32'h8000_0006, 32'h0, 4'b0000, 3'b010);
        chk("mis_valid", {31'b0, o_valid}, 32'h1);
        chk("mis_req", {31'b0, o_mem_req}, 32'h0);
        chk("mis_flag", {31'b0, o_misalign}, 32'h1);
        chk("mis_wb", o_wb_data, 32'h0);
        step();
        chk("mis_hold", {31'b0, o_misalign}, 32'h1);

        // SW with bus error
        issue(1'b0, 1'b1, 32'h8000_0010, 32'h1122_3344, 4'b1111, 3'b000);
        chk("sw_wstrb", {28'b0, o_mem_wstrb}, 32'h0000_000F);
        chk("sw_wdata", o_mem_wdata, 32'h1122_3344);
        chk("sw_mis_clr", {31'b0, o_misalign}, 32'h0);
        ack_after(1, 32'h0, 1'b1);
        chk("sw_valid", {31'b0, o_valid}, 32'h1);
        chk("sw_fault", {31'b0, o_fault}, 32'h1);
        step();

        // Next ALU op clears the fault
        issue(1'b0, 1'b0, 32'h0000_CAFE, 32'h0, 4'b0000, 3'b000);
        chk("clr_valid", {31'b0, o_valid}, 32'h1);
        chk("clr_fault", {31'b0, o_fault}, 32'h0);
        chk("clr_wb", o_wb_data, 32'h0000_CAFE);
        step();

        // Reset while a request is outstanding, then a late ack in IDLE
        issue(1'b1, 1'b0, 32'h8000_0020, 32'h0, 4'b0000, 3'b010);
        chk("rr_req", {31'b0, o_mem_req}, 32'h1);
        i_reset_n = 1'b0;
        step();
        chk("rr_req_drop", {31'b0, o_mem_req}, 32'h0);
        chk("rr_valid", {31'b0, o_valid}, 32'h0);
        i_reset_n = 1'b1;
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'hFFFF_FFFF;
        step();
        i_mem_ack = 1'b0;
        chk("late_ack_valid", {31'b0, o_valid}, 32'h0);
        chk("late_ack_req", {31'b0, o_mem_req}, 32'h0);

        // A subsequent LW completes normally
        issue(1'b1, 1'b0, 32'h8000_0020, 32'h0, 4'b0000, 3'b010);
        chk("lw_addr", o_mem_addr, 32'h8000_0020);
        ack_after(1, 32'h1357_9BDF, 1'b0);
        chk("lw_valid", {31'b0, o_valid}, 32'h1);
        chk("lw_wb", o_wb_data, 32'h1357_9BDF);
        chk("lw_fault", {31'b0, o_fault}, 32'h0);
        step();
        chk("lw_valid_drop", {31'b0, o_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
